// File: rtl/data_cache_pkg.sv
// Shared definitions for the direct-mapped write-through data cache:
// FSM encoding, word size and address-split width helpers.
package data_cache_pkg;

   localparam int unsigned WORD_BYTES = 4;

   localparam logic [0:0] S_IDLE   = 1'b0;
   localparam logic [0:0] S_REFILL = 1'b1;

   function automatic int unsigned offset_bits(input int unsigned line_words);
      return $clog2(line_words);
   endfunction

   function automatic int unsigned index_bits(input int unsigned num_lines);
      return $clog2(num_lines);
   endfunction

   function automatic int unsigned tag_bits(input int unsigned num_lines,
                                            input int unsigned line_words);
      return 32 - $clog2(WORD_BYTES) - offset_bits(line_words) - index_bits(num_lines);
   endfunction

endpackage

// File: rtl/data_cache_refill_fsm.sv
// Refill sequencer: IDLE/REFILL state, word counter, latched line base,
// stall and data-port address generation.
module data_cache_refill_fsm
   import data_cache_pkg::*;
#(
   parameter int unsigned LINE_WORDS = 4,
   localparam int unsigned OB = offset_bits(LINE_WORDS)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          miss,
   input  logic [31:0]   cpu_address,
   output logic          refill,
   output logic          last,
   output logic [OB-1:0] cnt,
   output logic          stall,
   output logic [31:0]   mem_address
);

   localparam logic [31:0] LINE_MASK = 32'(LINE_WORDS * WORD_BYTES - 1);

   logic [0:0]    state_q, state_d;
   logic [OB-1:0] cnt_q, cnt_d;
   logic [31:0]   base_q, base_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      base_d  = base_q;
      case (state_q)
         S_IDLE: begin
            if (miss) begin
               state_d = S_REFILL;
               cnt_d   = '0;
               base_d  = cpu_address & ~LINE_MASK;
            end
         end
         S_REFILL: begin
            if (cnt_q == OB'(LINE_WORDS - 1)) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         base_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         base_q  <= base_d;
      end
   end

   assign refill = (state_q == S_REFILL);
   assign last   = refill && (cnt_q == OB'(LINE_WORDS - 1));
   assign cnt    = cnt_q;

   // Outputs are forced to zero while reset is held, independent of inputs.
   assign stall       = rst_n && (refill || miss);
   assign mem_address = !rst_n ? 32'd0 :
                        refill ? base_q + {{(30 - OB){1'b0}}, cnt_q, 2'b00} : cpu_address;

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache.
// Define DATA_CACHE_STATS_EN to add hit_count/miss_count outputs.
module data_cache
   import data_cache_pkg::*;
#(
   parameter int unsigned NUM_LINES  = 64,
   parameter int unsigned LINE_WORDS = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] cpu_address,
   input  logic        cpu_read_enable,
   input  logic        cpu_write_enable,
   input  logic [3:0]  cpu_byte_enable,
   input  logic [31:0] cpu_write_data,
   output logic [31:0] cpu_read_data,
   output logic        stall,
   output logic [31:0] mem_address,
   output logic [31:0] mem_write_data,
   output logic        mem_write_enable,
   output logic [3:0]  mem_byte_enable,
`ifdef DATA_CACHE_STATS_EN
   output logic [31:0] hit_count,
   output logic [31:0] miss_count,
`endif
   input  logic [31:0] mem_read_data
);

   localparam int unsigned OB = offset_bits(LINE_WORDS);
   localparam int unsigned IB = index_bits(NUM_LINES);
   localparam int unsigned TB = tag_bits(NUM_LINES, LINE_WORDS);

   logic [OB-1:0] word;
   logic [IB-1:0] idx;
   logic [TB-1:0] addr_tag;

   assign word     = cpu_address[2 +: OB];
   assign idx      = cpu_address[OB + 2 +: IB];
   assign addr_tag = cpu_address[31 -: TB];

   logic [NUM_LINES-1:0] valid_q;
   logic [TB-1:0]        tag_q  [NUM_LINES];
   logic [31:0]          data_q [NUM_LINES][LINE_WORDS];

   logic          refill, last, hit, read_hit, miss, write_go;
   logic [OB-1:0] cnt;

   assign hit      = valid_q[idx] && (tag_q[idx] == addr_tag);
   assign write_go = rst_n && !refill && cpu_write_enable;
   assign read_hit = !refill && cpu_read_enable && !cpu_write_enable && hit;
   assign miss     = !refill && cpu_read_enable && !cpu_write_enable && !hit;

   data_cache_refill_fsm #(
      .LINE_WORDS (LINE_WORDS)
   ) u_refill_fsm (
      .clk         (clk),
      .rst_n       (rst_n),
      .miss        (miss),
      .cpu_address (cpu_address),
      .refill      (refill),
      .last        (last),
      .cnt         (cnt),
      .stall       (stall),
      .mem_address (mem_address)
   );

   // The line is invalidated when its refill starts, so an interrupted refill
   // never leaves a stale tag over partially overwritten data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= '0;
      end else if (miss) begin
         valid_q[idx] <= 1'b0;
      end else if (last) begin
         valid_q[idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (last) begin
         tag_q[idx] <= addr_tag;
      end
      if (refill) begin
         data_q[idx][cnt] <= mem_read_data;
      end else if (write_go && hit) begin
         for (int b = 0; b < 4; b++) begin
            if (cpu_byte_enable[b]) begin
               data_q[idx][word][8*b +: 8] <= cpu_write_data[8*b +: 8];
            end
         end
      end
   end

   assign cpu_read_data    = read_hit ? data_q[idx][word] : 32'd0;
   assign mem_write_enable = write_go;
   assign mem_write_data   = write_go ? cpu_write_data : 32'd0;
   assign mem_byte_enable  = write_go ? cpu_byte_enable : 4'd0;

`ifdef DATA_CACHE_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         if (read_hit) hit_count <= hit_count + 32'd1;
         if (miss)     miss_count <= miss_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_data_cache.sv
// Directed self-checking bench for data_cache with a word-array memory model.
module tb_data_cache;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] cpu_address;
   logic        cpu_read_enable;
   logic        cpu_write_enable;
   logic [3:0]  cpu_byte_enable;
   logic [31:0] cpu_write_data;
   logic [31:0] cpu_read_data;
   logic        stall;
   logic [31:0] mem_address;
   logic [31:0] mem_write_data;
   logic        mem_write_enable;
   logic [3:0]  mem_byte_enable;
   logic [31:0] mem_read_data;
`ifdef DATA_CACHE_STATS_EN
   logic [31:0] hit_count;
   logic [31:0] miss_count;
`endif

   int errors = 0;
   int checks = 0;
   int exp_hits = 0;
   int exp_misses = 0;

   logic [31:0] mem [0:4095];

   always #5 clk = ~clk;

   data_cache dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .cpu_address      (cpu_address),
      .cpu_read_enable  (cpu_read_enable),
      .cpu_write_enable (cpu_write_enable),
      .cpu_byte_enable  (cpu_byte_enable),
      .cpu_write_data   (cpu_write_data),
      .cpu_read_data    (cpu_read_data),
      .stall            (stall),
      .mem_address      (mem_address),
      .mem_write_data   (mem_write_data),
      .mem_write_enable (mem_write_enable),
      .mem_byte_enable  (mem_byte_enable),
`ifdef DATA_CACHE_STATS_EN
      .hit_count        (hit_count),
      .miss_count       (miss_count),
`endif
      .mem_read_data    (mem_read_data)
   );

   assign mem_read_data = mem[mem_address[13:2]];

   always @(posedge clk) begin
      if (mem_write_enable) begin
         for (int b = 0; b < 4; b++) begin
            if (mem_byte_enable[b]) mem[mem_address[13:2]][8*b +: 8] <= mem_write_data[8*b +: 8];
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Holds a load until it completes; checks stall length, refill addresses and data.
   task automatic do_read(input logic [31:0] addr, input int exp_stall,
                          input logic [31:0] exp_data, input string tag);
      int stalls = 0;
      logic [31:0] base = addr & ~32'hF;
      cpu_address     = addr;
      cpu_read_enable = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (!stall) break;
         if (k > 0) check({tag, "_maddr"}, mem_address, base + 32'((k - 1) * 4));
         stalls++;
         @(posedge clk);
         #1;
      end
      check({tag, "_stall"}, 32'(stalls), 32'(exp_stall));
      check({tag, "_data"}, cpu_read_data, exp_data);
      @(posedge clk);
      #1;
      cpu_read_enable = 1'b0;
      exp_hits++;
      if (exp_stall != 0) exp_misses++;
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] be, input string tag);
      cpu_address      = addr;
      cpu_write_data   = data;
      cpu_byte_enable  = be;
      cpu_write_enable = 1'b1;
      @(negedge clk);
      check({tag, "_we"}, 32'(mem_write_enable), 32'd1);
      check({tag, "_be"}, 32'(mem_byte_enable), 32'(be));
      check({tag, "_maddr"}, mem_address, addr);
      check({tag, "_wdata"}, mem_write_data, data);
      check({tag, "_stall"}, 32'(stall), 32'd0);
      @(posedge clk);
      #1;
      cpu_write_enable = 1'b0;
      cpu_byte_enable  = 4'd0;
      cpu_write_data   = 32'd0;
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = 32'h5A00_0000 + 32'(i);
      mem[32'h100 >> 2] = 32'hDEAD_BEEF;

      // Requests asserted during reset must not leak to the outputs.
      rst_n            = 1'b0;
      cpu_address      = 32'h100;
      cpu_read_enable  = 1'b1;
      cpu_write_enable = 1'b1;
      cpu_byte_enable  = 4'hF;
      cpu_write_data   = 32'hFFFF_FFFF;
      #2;
      check("rst_stall", 32'(stall), 32'd0);
      check("rst_we", 32'(mem_write_enable), 32'd0);
      check("rst_be", 32'(mem_byte_enable), 32'd0);
      check("rst_maddr", mem_address, 32'd0);
      check("rst_wdata", mem_write_data, 32'd0);
      check("rst_rdata", cpu_read_data, 32'd0);
      @(posedge clk);
      #1;
      cpu_read_enable  = 1'b0;
      cpu_write_enable = 1'b0;
      cpu_byte_enable  = 4'd0;
      cpu_write_data   = 32'd0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      do_read(32'h100, 5, 32'hDEAD_BEEF, "rd100_miss");
      do_read(32'h104, 0, 32'h5A00_0041, "rd104_hit");

      do_write(32'h100, 32'h0000_00AA, 4'b0001, "wr_hit");
      do_read(32'h100, 0, 32'hDEAD_BEAA, "rd100_after_wr");

      do_write(32'h2000, 32'h1234_5678, 4'b1111, "wr_miss");
      do_read(32'h2000, 5, 32'h1234_5678, "rd2000_miss");

      do_read(32'h500, 5, 32'h5A00_0140, "rd500_evict");
      do_read(32'h100, 5, 32'hDEAD_BEAA, "rd100_reload");

      // Reset while the refill counter is at 2.
      cpu_address     = 32'h300;
      cpu_read_enable = 1'b1;
      @(negedge clk);
      check("rr_detect_stall", 32'(stall), 32'd1);
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      check("rr_cnt2_maddr", mem_address, 32'h308);
      rst_n = 1'b0;
      #1;
      check("rr_stall", 32'(stall), 32'd0);
      check("rr_maddr", mem_address, 32'd0);
      check("rr_rdata", cpu_read_data, 32'd0);
      check("rr_we", 32'(mem_write_enable), 32'd0);
      exp_hits   = 0;
      exp_misses = 0;
`ifdef DATA_CACHE_STATS_EN
      check("rr_hit_count", hit_count, 32'd0);
      check("rr_miss_count", miss_count, 32'd0);
`endif
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      do_read(32'h300, 5, 32'h5A00_00C0, "rr_reread");
      do_read(32'h304, 0, 32'h5A00_00C1, "rd304_hit");
      do_read(32'h308, 0, 32'h5A00_00C2, "rd308_hit");
      do_read(32'h30C, 0, 32'h5A00_00C3, "rd30c_hit");
      do_write(32'h300, 32'hCAFE_0000, 4'b1100, "wr300");
      @(negedge clk);
      check("idle_rdata", cpu_read_data, 32'd0);
`ifdef DATA_CACHE_STATS_EN
      check("hit_count", hit_count, 32'(exp_hits));
      check("miss_count", miss_count, 32'(exp_misses));
`endif
      do_read(32'h300, 0, 32'hCAFE_00C0, "rd300_after_wr");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
